// File: rtl/debounce_pkg.sv
// Shared types and limits for the debounce_sync block.
// Optional build macro used by the block: DEBOUNCE_GLITCH_CNT_EN.
package debounce_pkg;

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        CONFIRM = 1'b1
    } state_e;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    function automatic bit in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchronizer for one asynchronous bit; no logic between stages.
module sync_chain #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw input through the synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{RESET_LEVEL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
        end
    end

    assign dout = sync_r[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces one asynchronous input, with one-cycle edge pulses.
// Build macro DEBOUNCE_GLITCH_CNT_EN adds a saturating rejected-glitch counter port.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter int   CNT_W           = 16,
    parameter logic RESET_LEVEL     = 1'b0,
    parameter int   GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                din_async,
    output logic                dout,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    if (!in_range(SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES)) begin : g_bad_sync
        $error("debounce_sync: SYNC_STAGES=%0d outside %0d..%0d",
               SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
    end
    if (DEBOUNCE_CYCLES < 1 ||
        longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - longint'(1))) begin : g_bad_cycles
        $error("debounce_sync: DEBOUNCE_CYCLES=%0d does not fit CNT_W=%0d",
               DEBOUNCE_CYCLES, CNT_W);
    end
    if (GLITCH_W < 1) begin : g_bad_glitch_w
        $error("debounce_sync: GLITCH_W must be at least 1");
    end

    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               SINGLE_EDGE = (DEBOUNCE_CYCLES == 1);

    logic             s_sync_s;
    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             dout_nxt_s;
    logic             rise_nxt_s;
    logic             fall_nxt_s;

    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din_async),
        .dout  (s_sync_s)
    );

    // Confirm FSM: a new level must persist for DEBOUNCE_CYCLES samples before dout follows.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        dout_nxt_s  = dout;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        case (state_r)
            STABLE: begin
                if (s_sync_s != dout) begin
                    if (SINGLE_EDGE) begin
                        dout_nxt_s = s_sync_s;
                        rise_nxt_s = s_sync_s;
                        fall_nxt_s = ~s_sync_s;
                        cnt_nxt_s  = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = CONFIRM;
                        cnt_nxt_s   = CNT_W'(1);
                    end
                end else begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            CONFIRM: begin
                if (s_sync_s != dout) begin
                    if (cnt_r == LAST_CNT) begin
                        dout_nxt_s  = s_sync_s;
                        rise_nxt_s  = s_sync_s;
                        fall_nxt_s  = ~s_sync_s;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = STABLE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    // Level fell back before confirmation: drop it silently.
                    state_nxt_s = STABLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s = STABLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, debounced level and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= STABLE;
            cnt_r      <= {CNT_W{1'b0}};
            dout       <= RESET_LEVEL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            dout       <= dout_nxt_s;
            rise_pulse <= rise_nxt_s;
            fall_pulse <= fall_nxt_s;
        end
    end

    assign busy = (state_r == CONFIRM);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                abort_s;
    logic [GLITCH_W-1:0] glitch_r;

    assign abort_s = (state_r == CONFIRM) && (s_sync_s == dout);

    // Saturating count of aborted confirmations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_r <= {GLITCH_W{1'b0}};
        end else if (abort_s && (glitch_r != {GLITCH_W{1'b1}})) begin
            glitch_r <= glitch_r + GLITCH_W'(1);
        end else begin
            glitch_r <= glitch_r;
        end
    end

    assign glitch_cnt = glitch_r;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: a DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1 instance share one input.
module tb_debounce_sync;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din_async = 1'b0;
    logic dout4, rise4, fall4, busy4;
    logic dout1, rise1, fall1, busy1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] gc4, gc1;
`endif

    always #5 clk = ~clk;

    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16),
                    .RESET_LEVEL(1'b0), .GLITCH_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .din_async(din_async), .dout(dout4),
        .rise_pulse(rise4), .fall_pulse(fall4), .busy(busy4)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(gc4)
`endif
    );

    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(16),
                    .RESET_LEVEL(1'b0), .GLITCH_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din_async(din_async), .dout(dout1),
        .rise_pulse(rise1), .fall_pulse(fall1), .busy(busy1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(gc1)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: hist[i] is the din value sampled i edges ago; the synchronized
    // sample seen by the filter at an edge is hist[SYNC]. dout flips when the last
    // D synchronized samples all differ from it.
    bit hist [0:7];
    int dcyc [2] = '{4, 1};
    bit m_dout [2];
    bit m_rise [2];
    bit m_fall [2];
    bit m_busy [2];
    int m_glitch [2];

    typedef struct {
        bit din;
        bit dout;
        bit rise;
        bit fall;
        bit busy;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) hist[i] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_dout[c] = 1'b0; m_rise[c] = 1'b0; m_fall[c] = 1'b0;
            m_busy[c] = 1'b0; m_glitch[c] = 0;
        end
    endtask

    task automatic model_step(input bit d);
        bit prev, acc, nd;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d;
        for (int c = 0; c < 2; c++) begin
            prev = m_dout[c];
            acc = 1'b1;
            for (int j = 0; j < dcyc[c]; j++) if (hist[SYNC+j] == prev) acc = 1'b0;
            nd = acc ? ~prev : prev;
            if (dcyc[c] > 1 && hist[SYNC] == prev && hist[SYNC+1] != prev && m_glitch[c] < 255)
                m_glitch[c]++;
            m_rise[c] = !prev && nd;
            m_fall[c] = prev && !nd;
            m_dout[c] = nd;
            m_busy[c] = (hist[SYNC] != nd);
        end
    endtask

    task automatic compare_all();
        chk("dout4", dout4, m_dout[0]); chk("rise4", rise4, m_rise[0]);
        chk("fall4", fall4, m_fall[0]); chk("busy4", busy4, m_busy[0]);
        chk("dout1", dout1, m_dout[1]); chk("rise1", rise1, m_rise[1]);
        chk("fall1", fall1, m_fall[1]); chk("busy1", busy1, m_busy[1]);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("glitch4", gc4, m_glitch[0]); chk("glitch1", gc1, m_glitch[1]);
`endif
    endtask

    task automatic tick(input bit d);
        din_async = d;
        @(posedge clk);
        model_step(d);
        #1;
        compare_all();
    endtask

    // Async reset mid-cycle, outputs checked while reset is held, release on a falling edge.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_dout4", dout4, 0); chk("rst_busy4", busy4, 0);
        chk("rst_rise4", rise4, 0); chk("rst_fall4", fall4, 0);
        chk("rst_dout1", dout1, 0); chk("rst_busy1", busy1, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("rst_glitch4", gc4, 0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void addv(input bit d, input bit o, input bit r, input bit f, input bit b);
        vec_t v;
        v.din = d; v.dout = o; v.rise = r; v.fall = f; v.busy = b;
        vecs.push_back(v);
    endfunction

    initial begin
        bit lvl;
        int len;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("por_dout4", dout4, 0); chk("por_busy4", busy4, 0);
        chk("por_rise4", rise4, 0); chk("por_fall4", fall4, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset release: nothing may move.
        repeat (20) tick(1'b0);
        chk("idle_dout4", dout4, 0);
        chk("idle_busy4", busy4, 0);

        // Expected D=4 response per edge: {din, dout, rise, fall, busy}.
        addv(1,0,0,0,0); addv(1,0,0,0,0); addv(1,0,0,0,1); addv(1,0,0,0,1);
        addv(1,0,0,0,1); addv(1,1,1,0,0); addv(1,1,0,0,0); addv(1,1,0,0,0);
        addv(0,1,0,0,0); addv(0,1,0,0,0); addv(0,1,0,0,1); addv(0,1,0,0,1);
        addv(0,1,0,0,1); addv(0,0,0,1,0); addv(0,0,0,0,0); addv(0,0,0,0,0);
        addv(1,0,0,0,0); addv(1,0,0,0,0); addv(1,0,0,0,1);
        addv(0,0,0,0,1); addv(0,0,0,0,1); addv(0,0,0,0,0); addv(0,0,0,0,0); addv(0,0,0,0,0);
        addv(1,0,0,0,0); addv(1,0,0,0,0); addv(1,0,0,0,1); addv(1,0,0,0,1);
        addv(0,0,0,0,1); addv(0,1,1,0,0); addv(0,1,0,0,1); addv(0,1,0,0,1);
        addv(0,1,0,0,1); addv(0,0,0,1,0); addv(0,0,0,0,0); addv(0,0,0,0,0); addv(0,0,0,0,0);
        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].din);
            chk($sformatf("tbl%0d_dout", i), dout4, vecs[i].dout);
            chk($sformatf("tbl%0d_rise", i), rise4, vecs[i].rise);
            chk($sformatf("tbl%0d_fall", i), fall4, vecs[i].fall);
            chk($sformatf("tbl%0d_busy", i), busy4, vecs[i].busy);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("short_high_glitch", gc4, 1);
`endif

        // Reset in CONFIRM with cnt=2, then the debounce restarts from scratch.
        repeat (4) tick(1'b1);
        chk("t5_busy_before_rst", busy4, 1);
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1);
            chk("t5_rise4", rise4, (i == 5) ? 1 : 0);
            chk("t5_dout4", dout4, (i >= 5) ? 1 : 0);
            chk("d1_rise", rise1, (i == 2) ? 1 : 0);
            chk("d1_dout", dout1, (i >= 2) ? 1 : 0);
        end
        repeat (10) tick(1'b0);

`ifdef DEBOUNCE_GLITCH_CNT_EN
        // 300 short pulses saturate an 8-bit glitch counter.
        repeat (300) begin
            tick(1'b1); tick(1'b1);
            repeat (4) tick(1'b0);
        end
        chk("glitch_saturate", gc4, 255);
        chk("glitch_d1_zero", gc1, 0);
        apply_reset();
`endif

        // Random run lengths with occasional resets, checked against the model.
        lvl = 1'b0;
        for (int r = 0; r < 400; r++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 7);
            repeat (len) tick(lvl);
            if ($urandom_range(0, 49) == 0) apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
